rgb_breath_sequencer: RTL and testbench
=======================================

Name: rgb_breath_sequencer

Overview:
Controller that drives the board's three LED pins (R, G, B) with breathing sequences. It owns one shared PWM timebase and one duty register, and applies them to one colour channel at a time. Each channel breathes (ramps up, then down) a configurable number of times before the sequencer hands the PWM to the next channel. Sits at top level between the 50 MHz clock and the LED pins.

Parameters:
CLK_DIV, 100, clk cycles per PWM tick (prescaler modulus, ≥2)
PWM_STEPS, 1000, ticks per PWM period; also number of duty levels (≥2)
BREATHS_PER_CH, 2, full up/down breaths per channel before advancing (≥1)
ACTIVE_LOW, 1, 1 = pin driven 0 when lit

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
enable  in  1  run sequencer; low forces idle
hold  in  1  freeze duty/state; PWM keeps running (steady brightness)
led_r  out  1  red pin
led_g  out  1  green pin
led_b  out  1  blue pin
active_ch  out  2  channel owning PWM: 0=R, 1=G, 2=B, 3=W
ramp_dn  out  1  1 while in RAMP_DOWN
cycle_done  out  1  1-clk pulse when sequence wraps back to R

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, pwm_cnt=0, duty=0, breath_cnt=0, active_ch=0, ramp_dn=0, cycle_done=0; all pins unlit (1 if ACTIVE_LOW, else 0). Reset mid-ramp aborts immediately; no state is retained.
- Timebase: prescaler counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1). pwm_cnt advances on tick and wraps at PWM_STEPS-1. period_end = tick && pwm_cnt==PWM_STEPS-1.
- Lit = (pwm_cnt < duty), registered, so the pin lags the comparator by 1 clk. duty=0 means never lit. duty=PWM_STEPS-1 means lit for all but one tick.
- Only the channel selected by active_ch uses Lit; the other pins are held unlit.
- FSM: IDLE, RAMP_UP, RAMP_DOWN.
  - IDLE: counters held at 0, pins unlit. enable=1 → RAMP_UP on the next clk; the timebase starts from 0.
  - RAMP_UP: on period_end, if duty<PWM_STEPS-1 then duty+1; else → RAMP_DOWN with duty unchanged.
  - RAMP_DOWN: on period_end, if duty>0 then duty-1. Otherwise breath_cnt is tested:
    - if breath_cnt<BREATHS_PER_CH-1: breath_cnt+1, → RAMP_UP.
    - else: breath_cnt=0, active_ch advances R→G→B→R, → RAMP_UP.
  - One breath = 2·PWM_STEPS periods.
- cycle_done asserts for the single clk on which active_ch wraps to 0.
- enable=0 in any state: synchronous → IDLE next clk; all counters and regs clear; pins unlit next clk. enable wins over hold.
- hold=1: state, duty, breath_cnt and active_ch are frozen, and period_end updates are ignored. The timebase and comparator keep running. Releasing hold resumes at the next period_end with no extra step.
- Simultaneous period_end and ramp boundary are resolved exactly as listed above; duty never leaves 0..PWM_STEPS-1.
- Widths: prescaler $clog2(CLK_DIV); pwm_cnt and duty $clog2(PWM_STEPS); breath_cnt $clog2(BREATHS_PER_CH+1).

Optional Feature:
BREATH_WHITE_EN
- Defined: the sequence is R→G→B→W→R. In W (active_ch=3) all three pins follow Lit together. cycle_done fires on the W→R wrap.
- Undefined: active_ch never equals 3. The W-pin logic is absent.

Decomposition:
- Package breath_pkg holds:
  - state enum (IDLE, RAMP_UP, RAMP_DOWN)
  - channel codes CH_R=0, CH_G=1, CH_B=2, CH_W=3
  - NUM_CH (3, or 4 with BREATH_WHITE_EN)
- Sub-module breath_pwm_timebase: prescaler plus pwm_cnt; outputs tick, pwm_cnt, period_end. It is cleared by rst or by sequencer idle.

Test Plan (CLK_DIV=2, PWM_STEPS=4, BREATHS_PER_CH=1, ACTIVE_LOW=1, so period = 8 clk and breath = 64 clk):
1. rst=1 with enable=1 → all pins 1, active_ch=0, cycle_done=0. Release rst → RAMP_UP next clk, led_r first lit when duty=1.
2. Free run → duty sequence per period: 0,1,2,3,3,2,1,0. active_ch 0→1 at clk 64 and 1→2 at clk 128. cycle_done pulses exactly once, 1 clk wide, at clk 192. G and B stay 1 while R owns the PWM.
3. duty=2 → led_r low for exactly 4 of 8 clk per period. duty=0 → led_r constantly 1.
4. hold=1 for 40 clk mid RAMP_UP at duty=2 → duty stays 2 and the PWM pattern keeps repeating. After release, duty=3 at the next period_end.
5. enable dropped in RAMP_DOWN on B → IDLE next clk, all pins 1. Re-enable → restart on R at duty=0.
6. With BREATH_WHITE_EN → after B, active_ch=3 and all three pins toggle identically. cycle_done at clk 256.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared state codes, channel codes and channel rotation for the breathing sequencer.
// Define BREATH_WHITE_EN to add the white channel (all pins together) to the rotation.
package breath_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } breath_state_e;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_W = 2'd3;

`ifdef BREATH_WHITE_EN
    localparam int NUM_CH = 4;
`else
    localparam int NUM_CH = 3;
`endif

    localparam logic [1:0] CH_LAST = 2'(NUM_CH - 1);

    function automatic logic [1:0] next_channel(input logic [1:0] ch);
        if (ch == CH_LAST) begin
            return CH_R;
        end else begin
            return ch + 2'd1;
        end
    endfunction

endpackage

// File: rtl/breath_pwm_timebase.sv
// Shared PWM timebase: clock prescaler feeding a PWM period counter.
// Held at zero while the sequencer is idle so every run starts on a period boundary.
module breath_pwm_timebase #(
    parameter int CLK_DIV   = 100,
    parameter int PWM_STEPS = 1000,
    localparam int CNT_W    = $clog2(PWM_STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic             period_end
);

    localparam int PS_W = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PWM_STEPS - 1);

    logic [PS_W-1:0] prescaler;

    assign tick       = (prescaler == PS_MAX);
    assign period_end = tick && (pwm_cnt == CNT_MAX);

    // Prescaler and PWM counter, both wrapping at their moduli.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (clear) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick) begin
                pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_breath_sequencer.sv
// RGB breathing sequencer: one shared PWM and duty ramp, handed from channel to channel.
// Define BREATH_WHITE_EN to append a white step where all three pins breathe together.
module rgb_breath_sequencer import breath_pkg::*; #(
    parameter int CLK_DIV        = 100,
    parameter int PWM_STEPS      = 1000,
    parameter int BREATHS_PER_CH = 2,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       hold,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [1:0] active_ch,
    output logic       ramp_dn,
    output logic       cycle_done
);

    localparam int CNT_W = $clog2(PWM_STEPS);
    localparam int BC_W  = $clog2(BREATHS_PER_CH + 1);
    localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PWM_STEPS - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BREATHS_PER_CH - 1);
    localparam logic             OFF      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_RAMP_UP   = 2'(RAMP_UP);
    localparam logic [1:0] ST_RAMP_DOWN = 2'(RAMP_DOWN);

    logic [1:0]       state;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] pwm_cnt;
    logic [BC_W-1:0]  breath_cnt;
    logic             tick;
    logic             period_end;
    logic             running;
    logic             step;
    logic             lit;
    logic             sel_r;
    logic             sel_g;
    logic             sel_b;

    assign running = enable && (state != ST_IDLE);
    assign step    = tick && period_end && !hold;
    assign lit     = running && (pwm_cnt < duty);

`ifdef BREATH_WHITE_EN
    assign sel_r = (active_ch == CH_R) || (active_ch == CH_W);
    assign sel_g = (active_ch == CH_G) || (active_ch == CH_W);
    assign sel_b = (active_ch == CH_B) || (active_ch == CH_W);
`else
    assign sel_r = (active_ch == CH_R);
    assign sel_g = (active_ch == CH_G);
    assign sel_b = (active_ch == CH_B);
`endif

    breath_pwm_timebase #(
        .CLK_DIV   (CLK_DIV),
        .PWM_STEPS (PWM_STEPS)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .clear      (!running),
        .tick       (tick),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end)
    );

    // Breathing FSM: duty ramps once per PWM period, channel advances after the last breath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty       <= '0;
            breath_cnt <= '0;
            active_ch  <= CH_R;
            ramp_dn    <= 1'b0;
            cycle_done <= 1'b0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            duty       <= '0;
            breath_cnt <= '0;
            active_ch  <= CH_R;
            ramp_dn    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!hold) begin
                        state <= ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (step) begin
                        if (duty != DUTY_MAX) begin
                            duty <= duty + CNT_W'(1);
                        end else begin
                            state   <= ST_RAMP_DOWN;
                            ramp_dn <= 1'b1;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (step) begin
                        if (duty != '0) begin
                            duty <= duty - CNT_W'(1);
                        end else begin
                            state   <= ST_RAMP_UP;
                            ramp_dn <= 1'b0;
                            if (breath_cnt != BC_LAST) begin
                                breath_cnt <= breath_cnt + BC_W'(1);
                            end else begin
                                breath_cnt <= '0;
                                active_ch  <= next_channel(active_ch);
                                cycle_done <= (next_channel(active_ch) == CH_R);
                            end
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    duty       <= '0;
                    breath_cnt <= '0;
                    active_ch  <= CH_R;
                    ramp_dn    <= 1'b0;
                end
            endcase
        end
    end

    // Pin drivers: comparator result registered onto the selected pin(s) only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= OFF;
            led_g <= OFF;
            led_b <= OFF;
        end else begin
            led_r <= (lit && sel_r) ? ~OFF : OFF;
            led_g <= (lit && sel_g) ? ~OFF : OFF;
            led_b <= (lit && sel_b) ? ~OFF : OFF;
        end
    end

endmodule

// File: tb/tb_rgb_breath_sequencer.sv
// Randomized self-checking bench for rgb_breath_sequencer; the reference model
// derives duty, channel and pins from elapsed PWM periods with plain arithmetic.
module tb_rgb_breath_sequencer;

    localparam int CLK_DIV = 2;
    localparam int S       = 4;
    localparam int B       = 1;
    localparam int PER     = CLK_DIV * S;
    localparam int BREATH  = 2 * S * PER * B;
`ifdef BREATH_WHITE_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       hold;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic [1:0] active_ch;
    logic       ramp_dn;
    logic       cycle_done;

    int total = 0;
    int bad   = 0;

    // reference model: running flag, clocks into current period, effective periods elapsed
    bit         m_run;
    int         m_t;
    int         m_p;
    logic [6:0] expv;
    logic [6:0] obs;

    assign obs = {led_r, led_g, led_b, active_ch, ramp_dn, cycle_done};

    always #5 clk = ~clk;

    rgb_breath_sequencer #(
        .CLK_DIV        (CLK_DIV),
        .PWM_STEPS      (S),
        .BREATHS_PER_CH (B),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hold       (hold),
        .led_r      (led_r),
        .led_g      (led_g),
        .led_b      (led_b),
        .active_ch  (active_ch),
        .ramp_dn    (ramp_dn),
        .cycle_done (cycle_done)
    );

    function automatic int duty_of(input int p);
        int k;
        k = p % (2 * S);
        return (k < S) ? k : (2 * S - 1 - k);
    endfunction

    function automatic int ch_of(input int p);
        return (p / (2 * S * B)) % NCH;
    endfunction

    task automatic mreset();
        m_run = 1'b0;
        m_t   = 0;
        m_p   = 0;
        expv  = 7'b111_00_0_0;
    endtask

    task automatic tick_model();
        bit lit;
        bit on_r;
        bit on_g;
        bit on_b;
        bit cd;
        int ch;
        on_r = 1'b0;
        on_g = 1'b0;
        on_b = 1'b0;
        cd   = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
            m_t   = 0;
            m_p   = 0;
        end else if (!m_run) begin
            if (!hold) begin
                m_run = 1'b1;
                m_t   = 0;
                m_p   = 0;
            end
        end else begin
            ch   = ch_of(m_p);
            lit  = (m_t / CLK_DIV) < duty_of(m_p);
            on_r = lit && (ch == 0 || ch == 3);
            on_g = lit && (ch == 1 || ch == 3);
            on_b = lit && (ch == 2 || ch == 3);
            if (m_t == PER - 1 && !hold) begin
                m_p = m_p + 1;
                cd  = (ch_of(m_p) == 0) && (ch != 0);
            end
            m_t = (m_t + 1) % PER;
        end
        expv = {!on_r, !on_g, !on_b, m_run ? 2'(ch_of(m_p)) : 2'd0,
                m_run && ((m_p % (2 * S)) >= S), cd};
    endtask

    // one clock: inputs already set at the negedge, model follows the posedge
    task automatic step();
        @(posedge clk);
        if (rst) mreset();
        else tick_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b1;
        hold   = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first_lit;
        rst    = 1'b1;
        enable = 1'b1;
        hold   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== 7'b111_00_0_0) begin
                bad++;
                $display("FAIL reset_state: got %b expected %b", obs, 7'b111_00_0_0);
            end
        end
        rst = 1'b0;
        first_lit = 0;
        for (int s = 1; s <= 20; s++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_release s=%0d: got %b expected %b", s, obs, expv);
            end
            if (first_lit == 0 && led_r == 1'b0) first_lit = s;
        end
        total++;
        if (first_lit !== 10) begin
            bad++;
            $display("FAIL first_lit: got %0d expected %0d", first_lit, 10);
        end
    endtask

    task automatic test_free_run();
        int cd_count;
        int cd_step;
        int first_g;
        int red_low;
        int green_low;
        cd_count = 0; cd_step = 0; first_g = 0; red_low = 0; green_low = 0;
        do_reset();
        for (int s = 1; s <= NCH * BREATH + 10; s++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL free_run s=%0d: got %b expected %b", s, obs, expv);
            end
            if (cycle_done) begin
                cd_count++;
                cd_step = s;
            end
            if (first_g == 0 && active_ch == 2'd1) first_g = s;
            if (s <= BREATH + 2 && led_r == 1'b0) red_low++;
            if (s <= BREATH + 2 && led_g == 1'b0) green_low++;
        end
        total++;
        if (cd_count !== 1 || cd_step !== 1 + NCH * BREATH) begin
            bad++;
            $display("FAIL cycle_done: got count=%0d at=%0d expected count=1 at=%0d",
                     cd_count, cd_step, 1 + NCH * BREATH);
        end
        total++;
        if (first_g !== 1 + BREATH) begin
            bad++;
            $display("FAIL ch_advance: got %0d expected %0d", first_g, 1 + BREATH);
        end
        total++;
        if (red_low !== 24 || green_low !== 0) begin
            bad++;
            $display("FAIL breath_lit_count: got r=%0d g=%0d expected r=24 g=0", red_low, green_low);
        end
    endtask

    task automatic test_hold();
        int held_low;
        int after_low;
        held_low = 0; after_low = 0;
        do_reset();
        for (int s = 1; s <= 80; s++) begin
            hold = (s >= 18 && s <= 57);
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL hold s=%0d: got %b expected %b", s, obs, expv);
            end
            if (s >= 18 && s <= 57 && led_r == 1'b0) held_low++;
            if (s >= 66 && s <= 73 && led_r == 1'b0) after_low++;
        end
        hold = 1'b0;
        total++;
        if (held_low !== 20) begin
            bad++;
            $display("FAIL hold_duty2: got %0d expected %0d", held_low, 20);
        end
        total++;
        if (after_low !== 6) begin
            bad++;
            $display("FAIL hold_resume_duty3: got %0d expected %0d", after_low, 6);
        end
    endtask

    task automatic test_enable_drop();
        int first_lit;
        do_reset();
        for (int s = 1; s <= 169; s++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL run_to_b s=%0d: got %b expected %b", s, obs, expv);
            end
        end
        total++;
        if (active_ch !== 2'd2 || ramp_dn !== 1'b1) begin
            bad++;
            $display("FAIL b_ramp_down: got ch=%0d dn=%b expected ch=2 dn=1", active_ch, ramp_dn);
        end
        enable = 1'b0;
        step();
        total++;
        if (obs !== 7'b111_00_0_0) begin
            bad++;
            $display("FAIL enable_drop: got %b expected %b", obs, 7'b111_00_0_0);
        end
        enable = 1'b1;
        first_lit = 0;
        for (int s = 1; s <= 20; s++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reenable s=%0d: got %b expected %b", s, obs, expv);
            end
            if (first_lit == 0 && led_r == 1'b0) first_lit = s;
        end
        total++;
        if (first_lit !== 10) begin
            bad++;
            $display("FAIL reenable_first_lit: got %0d expected %0d", first_lit, 10);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 3000; s++) begin
            enable = ($urandom_range(0, 99) < 98);
            if ($urandom_range(0, 99) < 4) hold = ~hold;
            if ($urandom_range(0, 999) < 4) begin
                rst = 1'b1;
                #1;
                mreset();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL async_reset s=%0d: got %b expected %b", s, obs, expv);
                end
                step();
                rst = 1'b0;
            end else begin
                step();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL random s=%0d en=%b hold=%b: got %b expected %b",
                             s, enable, hold, obs, expv);
                end
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        hold   = 1'b0;
        mreset();
        @(negedge clk);
        test_reset();
        test_free_run();
        test_hold();
        test_enable_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
